// File: rtl/sdram_arbit.sv
// sdram_arbit: arbitrates the SDRAM command bus between the init sequencer,
// the auto-refresh block and the write/read burst blocks.
//
// Ports
//   sclk, s_rst_n                     clock, async active-low reset
//   init_end/init_cmd/init_addr       init sequencer done flag and bus
//   ref_req/ref_end/ref_cmd/ref_addr  refresh request, done pulse and bus
//   wr_req/wr_end/wr_cmd/wr_bank/wr_addr   write request, done pulse and bus
//   rd_req/rd_end/rd_cmd/rd_bank/rd_addr   read request, done pulse and bus
//   ref_en/wr_en/rd_en                grants to the sub-blocks
//   ref_pend                          refresh waiting; burst blocks stop early
//   sdram_*                           muxed SDRAM command/address bus
//   arb_state                         current state code (debug)
//
// state | meaning
// IDLE  | waiting for the init sequencer to finish; init owns the bus
// ARBIT | choosing the next operation; bus drives NOP
// AREF  | refresh block owns the bus until ref_end
// WRITE | write block owns the bus until wr_end
// READ  | read block owns the bus until rd_end

module sdram_arbit #(
    parameter logic [3:0] CMD_NOP = 4'b0111
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [11:0] init_addr,
    input  logic        ref_req,
    input  logic        ref_end,
    input  logic [3:0]  ref_cmd,
    input  logic [11:0] ref_addr,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_bank,
    input  logic [11:0] wr_addr,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_bank,
    input  logic [11:0] rd_addr,
    output logic        ref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic        ref_pend,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_bank,
    output logic [11:0] sdram_addr,
    output logic [2:0]  arb_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARBIT = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   ref_p_q, ref_p_d;
    logic   wr_p_q, wr_p_d;
    logic   rd_p_q, rd_p_d;
    logic   ref_en_q, ref_en_d;
    logic   wr_en_q, wr_en_d;
    logic   rd_en_q, rd_en_d;
    logic   cke_q;
    logic [3:0] cmd;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q  <= IDLE;
            ref_p_q  <= 1'b0;
            wr_p_q   <= 1'b0;
            rd_p_q   <= 1'b0;
            ref_en_q <= 1'b0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            cke_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_p_q  <= ref_p_d;
            wr_p_q   <= wr_p_d;
            rd_p_q   <= rd_p_d;
            ref_en_q <= ref_en_d;
            wr_en_q  <= wr_en_d;
            rd_en_q  <= rd_en_d;
            cke_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        ref_en_d = ref_en_q;
        wr_en_d  = wr_en_q;
        rd_en_d  = rd_en_q;
        ref_p_d  = ref_p_q;
        wr_p_d   = wr_p_q;
        rd_p_d   = rd_p_q;

        // Requests are only remembered once init is done; a request seen
        // during its own operation stays pending for a later grant.
        if (state_q != IDLE) begin
            ref_p_d = ref_p_q | ref_req;
            wr_p_d  = wr_p_q | wr_req;
            rd_p_d  = rd_p_q | rd_req;
        end

        case (state_q)
            IDLE: begin
                if (init_end) state_d = ARBIT;
            end
            ARBIT: begin
                if (ref_p_q || ref_req) begin
                    state_d  = AREF;
                    ref_en_d = 1'b1;
                    ref_p_d  = 1'b0;
                end else if (wr_p_q || wr_req) begin
                    state_d = WRITE;
                    wr_en_d = 1'b1;
                    wr_p_d  = 1'b0;
                end else if (rd_p_q || rd_req) begin
                    state_d = READ;
                    rd_en_d = 1'b1;
                    rd_p_d  = 1'b0;
                end
            end
            AREF: begin
                if (ref_end) begin
                    state_d  = ARBIT;
                    ref_en_d = 1'b0;
                end
            end
            WRITE: begin
                if (wr_end) begin
                    state_d = ARBIT;
                    wr_en_d = 1'b0;
                end
            end
            READ: begin
                if (rd_end) begin
                    state_d = ARBIT;
                    rd_en_d = 1'b0;
                end
            end
            default: begin
                state_d  = ARBIT;
                ref_en_d = 1'b0;
                wr_en_d  = 1'b0;
                rd_en_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        cmd        = CMD_NOP;
        sdram_bank = 2'd0;
        sdram_addr = 12'd0;
        case (state_q)
            IDLE: begin
                cmd        = init_cmd;
                sdram_addr = init_addr;
            end
            AREF: begin
                cmd        = ref_cmd;
                sdram_addr = ref_addr;
            end
            WRITE: begin
                cmd        = wr_cmd;
                sdram_bank = wr_bank;
                sdram_addr = wr_addr;
            end
            READ: begin
                cmd        = rd_cmd;
                sdram_bank = rd_bank;
                sdram_addr = rd_addr;
            end
            default: begin
                cmd        = CMD_NOP;
                sdram_bank = 2'd0;
                sdram_addr = 12'd0;
            end
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

    assign ref_en    = ref_en_q;
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign ref_pend  = ref_p_q;
    assign sdram_cke = cke_q;
    assign arb_state = state_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit. The stimulus thread pushes the expected
// snapshot of every state change into a queue; the monitor pops one entry
// each time arb_state changes and compares grants, ref_pend, cke and bus.
module tb_sdram_arbit;

    localparam logic [2:0] S_IDLE = 3'd0, S_ARBIT = 3'd1, S_AREF = 3'd2,
                           S_WRITE = 3'd3, S_READ = 3'd4;

    localparam logic [3:0]  INIT_CMD = 4'b0001, REF_CMD = 4'b0010,
                            WR_CMD = 4'b0100, RD_CMD = 4'b0101, NOP = 4'b0111;
    localparam logic [11:0] INIT_ADDR = 12'h111, REF_ADDR = 12'h222,
                            WR_ADDR = 12'h333, RD_ADDR = 12'h444;
    localparam logic [1:0]  WR_BANK = 2'd1, RD_BANK = 2'd2;

    logic        sclk = 1'b0;
    logic        s_rst_n;
    logic        init_end, ref_req, ref_end, wr_req, wr_end, rd_req, rd_end;
    logic        ref_en, wr_en, rd_en, ref_pend, sdram_cke;
    logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_bank;
    logic [11:0] sdram_addr;
    logic [2:0]  arb_state;

    typedef struct {
        logic [2:0] st;
        logic       ref_en;
        logic       wr_en;
        logic       rd_en;
        logic       pend;
        logic       cke;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 sclk = ~sclk;

    sdram_arbit #(.CMD_NOP(4'b0111)) dut (
        .sclk(sclk), .s_rst_n(s_rst_n),
        .init_end(init_end), .init_cmd(INIT_CMD), .init_addr(INIT_ADDR),
        .ref_req(ref_req), .ref_end(ref_end), .ref_cmd(REF_CMD), .ref_addr(REF_ADDR),
        .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(WR_CMD), .wr_bank(WR_BANK),
        .wr_addr(WR_ADDR),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(RD_CMD), .rd_bank(RD_BANK),
        .rd_addr(RD_ADDR),
        .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en), .ref_pend(ref_pend),
        .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
        .sdram_bank(sdram_bank), .sdram_addr(sdram_addr), .arb_state(arb_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {cmd, bank, addr} for a given state.
    function automatic logic [17:0] bus_of(input logic [2:0] st);
        case (st)
            S_IDLE:  return {INIT_CMD, 2'd0, INIT_ADDR};
            S_AREF:  return {REF_CMD, 2'd0, REF_ADDR};
            S_WRITE: return {WR_CMD, WR_BANK, WR_ADDR};
            S_READ:  return {RD_CMD, RD_BANK, RD_ADDR};
            default: return {NOP, 2'd0, 12'd0};
        endcase
    endfunction

    function automatic logic [17:0] bus_now();
        return {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_bank, sdram_addr};
    endfunction

    task automatic push(input logic [2:0] st, input logic r, input logic w,
                        input logic d, input logic p, input logic c);
        exp_t e;
        e.st = st; e.ref_en = r; e.wr_en = w; e.rd_en = d; e.pend = p; e.cke = c;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    // Monitor: one queue entry per observed state change.
    initial begin : monitor
        logic [2:0] prev;
        exp_t e;
        prev = S_IDLE;
        forever begin
            @(negedge sclk);
            if (arb_state !== prev) begin
                prev = arb_state;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_transition: got state %0d expected no change at %0t",
                             arb_state, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_state", 32'(arb_state), 32'(e.st));
                    check("mon_grants", 32'({ref_en, wr_en, rd_en}),
                          32'({e.ref_en, e.wr_en, e.rd_en}));
                    check("mon_ref_pend", 32'(ref_pend), 32'(e.pend));
                    check("mon_cke", 32'(sdram_cke), 32'(e.cke));
                    check("mon_bus", 32'(bus_now()), 32'(bus_of(e.st)));
                end
            end
        end
    end

    initial begin : stimulus
        s_rst_n = 1'b0;
        init_end = 0; ref_req = 0; ref_end = 0; wr_req = 0; wr_end = 0;
        rd_req = 0; rd_end = 0;
        repeat (2) @(posedge sclk);
        #1;
        check("rst_state", 32'(arb_state), 32'(S_IDLE));
        check("rst_grants", 32'({ref_en, wr_en, rd_en, ref_pend}), 32'd0);
        check("rst_cke", 32'(sdram_cke), 32'd0);
        check("rst_bus", 32'(bus_now()), 32'(bus_of(S_IDLE)));
        s_rst_n = 1'b1;

        // init handshake: IDLE through cycle 10, ARBIT from cycle 11
        for (int c = 1; c <= 10; c++) begin
            tick();
            check("init_idle", 32'(arb_state), 32'(S_IDLE));
        end
        check("init_cke", 32'(sdram_cke), 32'd1);
        push(S_ARBIT, 0, 0, 0, 0, 1);
        init_end = 1; tick(); init_end = 0;
        repeat (2) tick();

        // single write
        push(S_WRITE, 0, 1, 0, 0, 1);
        wr_req = 1; tick(); wr_req = 0;
        repeat (7) tick();
        check("wr_hold", 32'({arb_state, wr_en}), 32'({S_WRITE, 1'b1}));
        push(S_ARBIT, 0, 0, 0, 0, 1);
        wr_end = 1; tick(); wr_end = 0;
        repeat (2) tick();

        // simultaneous refresh + write: refresh first, write after one ARBIT
        push(S_AREF, 1, 0, 0, 0, 1);
        ref_req = 1; wr_req = 1; tick(); ref_req = 0; wr_req = 0;
        repeat (3) tick();
        push(S_ARBIT, 0, 0, 0, 0, 1);
        push(S_WRITE, 0, 1, 0, 0, 1);
        ref_end = 1; tick(); ref_end = 0;
        check("arbit_gap", 32'(arb_state), 32'(S_ARBIT));
        tick();
        check("write_after_ref", 32'(arb_state), 32'(S_WRITE));

        // refresh request during WRITE raises ref_pend, write continues
        ref_req = 1; tick(); ref_req = 0;
        check("pend_set", 32'({arb_state, ref_pend}), 32'({S_WRITE, 1'b1}));
        repeat (3) tick();
        check("pend_hold", 32'({arb_state, ref_pend}), 32'({S_WRITE, 1'b1}));
        push(S_ARBIT, 0, 0, 0, 1, 1);
        push(S_AREF, 1, 0, 0, 0, 1);
        wr_end = 1; tick(); wr_end = 0;
        repeat (3) tick();
        push(S_ARBIT, 0, 0, 0, 0, 1);
        ref_end = 1; tick(); ref_end = 0;
        repeat (2) tick();

        // read with a second rd_req and a stray wr_end during READ
        push(S_READ, 0, 0, 1, 0, 1);
        rd_req = 1; tick(); rd_req = 0;
        tick();
        rd_req = 1; tick(); rd_req = 0;
        wr_end = 1; ref_end = 1; tick(); wr_end = 0; ref_end = 0;
        check("stray_end", 32'({arb_state, rd_en}), 32'({S_READ, 1'b1}));
        tick();
        push(S_ARBIT, 0, 0, 0, 0, 1);
        push(S_READ, 0, 0, 1, 0, 1);
        rd_end = 1; tick(); rd_end = 0;
        repeat (3) tick();
        push(S_ARBIT, 0, 0, 0, 0, 1);
        rd_end = 1; tick(); rd_end = 0;
        repeat (2) tick();

        // reset mid-WRITE with a read pending
        push(S_WRITE, 0, 1, 0, 0, 1);
        wr_req = 1; tick(); wr_req = 0;
        tick();
        rd_req = 1; tick(); rd_req = 0;
        push(S_IDLE, 0, 0, 0, 0, 0);
        #2;
        s_rst_n = 1'b0;
        #1;
        check("rst_mid_state", 32'(arb_state), 32'(S_IDLE));
        check("rst_mid_out", 32'({wr_en, sdram_cke}), 32'd0);
        tick();
        s_rst_n = 1'b1;
        repeat (4) tick();
        check("post_rst_idle", 32'({arb_state, rd_en}), 32'({S_IDLE, 1'b0}));
        push(S_ARBIT, 0, 0, 0, 0, 1);
        init_end = 1; tick(); init_end = 0;
        repeat (3) tick();
        check("no_stale_read", 32'({arb_state, rd_en}), 32'({S_ARBIT, 1'b0}));

        repeat (2) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
